// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
// The build macro SERIAL_ADDSUB_SUB_EN is consumed by serial_addsub.sv, not here.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } addsub_state_t;

    // One bit wider than needed for W-1 so the counter can step past the last bit without wrapping
    function automatic int cntWidth(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/serial_addsub_fa.sv
// Single full-adder cell with a registered carry, the arithmetic core of serial_addsub.
// carry_in_o is the registered carry feeding the adder this cycle; carry_out_o is its next value.
module serial_fa_cell
    import serial_addsub_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic preset_i,
    input  logic en_i,
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_in_o,
    output logic carry_out_o
);

    logic carry_q;

    assign carry_in_o  = carry_q;
    assign sum_o       = a_i ^ b_i ^ carry_q;
    assign carry_out_o = (a_i & b_i) | (a_i & carry_q) | (b_i & carry_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            carry_q <= 1'b0;
        end else if (load_i) begin
            carry_q <= preset_i;
        end else if (en_i) begin
            carry_q <= carry_out_o;
        end
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial W-bit adder/subtractor with valid/ready handshakes on both sides.
// Define SERIAL_ADDSUB_SUB_EN to make the sub port functional; otherwise only addition is built.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int CW = cntWidth(W);

    addsub_state_t  state_q, state_d;
    logic [W-1:0]   ra_q, ra_d, rb_q, rb_d, sum_q, sum_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           cout_q, cout_d, ovf_q, ovf_d;
    logic           subEff, accept, step, lastStep;
    logic           sumBit, carryIn, carryOut;
    logic [W-1:0]   raShifted;

`ifdef SERIAL_ADDSUB_SUB_EN
    assign subEff = sub;
`else
    assign subEff = sub & 1'b0;
`endif

    assign accept   = (state_q == IDLE) && in_valid;
    assign step     = (state_q == SHIFT);
    assign lastStep = step && (cnt_q == CW'(W - 1));

    // RA doubles as the result register: sum bits enter at the MSB as operand bits leave at the LSB
    generate
        if (W == 1) begin : gShiftOne
            assign raShifted = sumBit;
        end else begin : gShiftMany
            assign raShifted = {sumBit, ra_q[W-1:1]};
        end
    endgenerate

    serial_fa_cell uFa (
        .clk_i       (clk),
        .rst_i       (rst),
        .load_i      (accept),
        .preset_i    (subEff),
        .en_i        (step),
        .a_i         (ra_q[0]),
        .b_i         (rb_q[0]),
        .sum_o       (sumBit),
        .carry_in_o  (carryIn),
        .carry_out_o (carryOut)
    );

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ra_d    = a;
                    rb_d    = subEff ? ~b : b;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                ra_d  = raShifted;
                rb_d  = rb_q >> 1;
                cnt_d = cnt_q + CW'(1);
                // Outputs only change once the full result exists, so they hold the previous result meanwhile
                if (lastStep) begin
                    sum_d   = raShifted;
                    cout_d  = carryOut;
                    ovf_d   = carryIn ^ carryOut;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub at W=8 plus a W=1 instance.
// Expected results follow SERIAL_ADDSUB_SUB_EN the same way the design does.
module tb_serial_addsub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, inValid, sub, outReady;
    logic [W-1:0] a, b;
    logic         inReady, outValid, cout, ovf;
    logic [W-1:0] sum;

    logic         rst1, inValid1, sub1, outReady1;
    logic [0:0]   a1, b1, sum1;
    logic         inReady1, outValid1, cout1, ovf1;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } result_t;

    result_t expQ[$];
    int compareCount  = 0;
    int mismatchCount = 0;
    int cycleCount    = 0;
    int acceptCycle   = 0;

    serial_addsub #(.W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
        .a(a), .b(b), .sub(sub), .out_valid(outValid), .out_ready(outReady),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    serial_addsub #(.W(1)) dutOne (
        .clk(clk), .rst(rst1), .in_valid(inValid1), .in_ready(inReady1),
        .a(a1), .b(b1), .sub(sub1), .out_valid(outValid1), .out_ready(outReady1),
        .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: signed overflow when both addends share a sign that the result does not
    function automatic result_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
        logic         sEff;
        logic [W-1:0] bb;
        logic [W:0]   full;
        result_t      r;
`ifdef SERIAL_ADDSUB_SUB_EN
        sEff = sv;
`else
        sEff = 1'b0;
`endif
        bb     = sEff ? ~bv : bv;
        full   = {1'b0, av} + {1'b0, bb} + {{W{1'b0}}, sEff};
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (av[W-1] == bb[W-1]) && (r.sum[W-1] != av[W-1]);
        return r;
    endfunction

    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
        int guard = 0;
        while (!inReady && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("in_ready_before_accept", inReady, 1);
        a = av; b = bv; sub = sv; inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        acceptCycle = cycleCount;
        expQ.push_back(model(av, bv, sv));
    endtask

    task automatic collectResult(input string tag, input int holdCycles);
        result_t expv;
        int waited = 0;
        outReady = 1'b0;
        while (!outValid && waited < 4 * W + 8) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput({tag, "_latency"}, cycleCount - acceptCycle, W);
        if (expQ.size() == 0) begin
            checkOutput({tag, "_scoreboard_empty"}, 0, 1);
            expv = '0;
        end else begin
            expv = expQ.pop_front();
        end
        for (int i = 0; i < holdCycles; i++) begin
            checkOutput({tag, "_hold_valid"}, outValid, 1);
            checkOutput({tag, "_hold_in_ready"}, inReady, 0);
            checkOutput({tag, "_hold_sum"}, sum, expv.sum);
            @(posedge clk); #1;
        end
        checkOutput({tag, "_valid"}, outValid, 1);
        checkOutput({tag, "_sum"}, sum, expv.sum);
        checkOutput({tag, "_cout"}, cout, expv.cout);
        checkOutput({tag, "_ovf"}, ovf, expv.ovf);
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        checkOutput({tag, "_retire_valid"}, outValid, 0);
        checkOutput({tag, "_retire_in_ready"}, inReady, 1);
        checkOutput({tag, "_keep_sum"}, sum, expv.sum);
    endtask

    initial begin
        int  waited;
        logic sawValid;
        result_t dropped;

        rst = 1'b1; inValid = 1'b0; sub = 1'b0; outReady = 1'b0; a = '0; b = '0;
        rst1 = 1'b1; inValid1 = 1'b0; sub1 = 1'b0; outReady1 = 1'b0; a1 = '0; b1 = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", inReady, 1);
        checkOutput("reset_out_valid", outValid, 0);
        checkOutput("reset_sum", sum, 0);
        checkOutput("reset_cout", cout, 0);
        checkOutput("reset_ovf", ovf, 0);
        rst = 1'b0; rst1 = 1'b0;

        applyStimulus(8'h5A, 8'h3C, 1'b0); collectResult("add_ovf", 0);
        applyStimulus(8'hFF, 8'h01, 1'b0); collectResult("add_carry", 5);
        applyStimulus(8'h10, 8'h20, 1'b1); collectResult("sub_neg", 0);
        applyStimulus(8'h80, 8'h01, 1'b1); collectResult("sub_ovf", 0);
        applyStimulus(8'h10, 8'h20, 1'b0); collectResult("add_plain", 0);

        // Operands offered mid-shift must not disturb the transaction in flight
        applyStimulus(8'h33, 8'h44, 1'b0);
        @(posedge clk); #1;
        a = 8'h11; b = 8'h11; inValid = 1'b1;
        checkOutput("shift_in_ready", inReady, 0);
        @(posedge clk); #1;
        inValid = 1'b0;
        collectResult("ignored_input", 5);
        applyStimulus(8'h7F, 8'h01, 1'b0); collectResult("after_ignore", 0);

        applyStimulus(8'hAA, 8'h55, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        dropped = expQ.pop_back();
        checkOutput("abort_in_ready", inReady, 1);
        checkOutput("abort_out_valid", outValid, 0);
        checkOutput("abort_sum", sum, 0);
        checkOutput("abort_cout", cout, 0);
        checkOutput("abort_ovf", ovf, 0);
        sawValid = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            if (outValid) sawValid = 1'b1;
        end
        checkOutput("abort_never_valid", sawValid, 0);
        applyStimulus(8'h01, 8'h02, 1'b0); collectResult("after_abort", 0);

        a1 = 1'b1; b1 = 1'b1; inValid1 = 1'b1;
        checkOutput("w1_in_ready", inReady1, 1);
        @(posedge clk); #1;
        inValid1 = 1'b0;
        waited = 0;
        while (!outValid1 && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("w1_latency", waited, 1);
        checkOutput("w1_sum", sum1, 0);
        checkOutput("w1_cout", cout1, 1);
        checkOutput("w1_ovf", ovf1, 1);
        outReady1 = 1'b1;
        @(posedge clk); #1;
        outReady1 = 1'b0;
        checkOutput("w1_retire", outValid1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
